// File: rtl/risc_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the read-owner encoding and the starvation counter sizing.
package risc_mem_pkg;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STARVE_W         = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DRD  = 2'd2
    } owner_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles a pending fetch was refused.
// Ports: clk, reset (sync, active-high), inc, clr -> count.
module starve_counter
    import risc_mem_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [STARVE_W-1:0] count
);

    logic [STARVE_W-1:0] count_q;
    logic [STARVE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access.
// Ports: clk/reset, if_* fetch side, d_* data side, mem_* RAM side.
module mem_arbiter
    import risc_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [AW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [AW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    input  logic [AW-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    owner_e              owner_q;
    owner_e              owner_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic                fetch_ok;
    logic                data_ok;

    // A flushed fetch is never granted, so a starved fetch under
    // flush does not block data traffic.
    assign fetch_ok = if_req & ~if_flush & ~reset;
    assign data_ok  = d_req & ~reset;

    always_comb begin
        if_gnt    = fetch_ok & ((starve_cnt >= LIMIT) | ~data_ok);
        d_gnt     = data_ok & ~if_gnt;
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (if_gnt) begin
            mem_addr = if_addr;
            owner_d  = OWN_IF;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            if (!d_we) begin
                owner_d = OWN_DRD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    starve_counter u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (if_req & ~if_gnt),
        .clr   (if_gnt | ~if_req),
        .count (starve_cnt)
    );

    // Reset gating drops a read granted just before reset asserted.
    assign if_rvalid = ~reset & ~if_flush & (owner_q == OWN_IF);
    assign d_rvalid  = ~reset & (owner_q == OWN_DRD);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule
